// File: rtl/multi_stream_prefetch_ctrl_if.sv
// Bus bundle for multi_stream_prefetch_ctrl: request snoop, window, backpressure,
// prefetch offer handshake and flush pulses. The slave modport is the controller side.
interface multi_stream_prefetch_ctrl_if #(
  parameter int ADDR_BITS = 64,
  parameter int CNT_BITS  = 6,
  parameter int ID_BITS   = 2
);
  logic                 en;
  logic                 inAddrReqValid;
  logic [ADDR_BITS-1:0] inAddrReq;
  logic [ADDR_BITS-1:0] bar;
  logic [ADDR_BITS-1:0] limit;
  logic                 almostFull;
  logic [CNT_BITS-1:0]  outstandingReqCnt;
  logic [CNT_BITS-1:0]  outstandingReqLimit;
  logic                 prefetchReady;
  logic                 rangeHit;
  logic                 prefetchValid;
  logic [ADDR_BITS-1:0] prefetchAddr;
  logic [ID_BITS-1:0]   prefetchStreamId;
  logic                 flushValid;
  logic [ID_BITS-1:0]   flushStreamId;

  modport master (
    output en, inAddrReqValid, inAddrReq, bar, limit, almostFull,
           outstandingReqCnt, outstandingReqLimit, prefetchReady,
    input  rangeHit, prefetchValid, prefetchAddr, prefetchStreamId,
           flushValid, flushStreamId
  );

  modport slave (
    input  en, inAddrReqValid, inAddrReq, bar, limit, almostFull,
           outstandingReqCnt, outstandingReqLimit, prefetchReady,
    output rangeHit, prefetchValid, prefetchAddr, prefetchStreamId,
           flushValid, flushStreamId
  );
endinterface

// File: rtl/multi_stream_prefetch_ctrl.sv
// Multi-stream block-aligned stride prefetcher with confidence training and RR issue.
// Define NEG_STRIDE_EN to allow descending (negative-stride) streams.
module multi_stream_prefetch_ctrl #(
  parameter int ADDR_BITS   = 64,
  parameter int BLOCK_BITS  = 6,
  parameter int NUM_STREAMS = 4,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int DEGREE      = 4,
  parameter int MAX_STRIDE  = 16,
  parameter int CNT_BITS    = 6
) (
  input logic                      clk,
  input logic                      resetN,
  multi_stream_prefetch_ctrl_if.slave pf_if
);

  localparam int ID_BITS = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int BW      = ADDR_BITS - BLOCK_BITS;
  localparam int AW      = $clog2(DEGREE + 1);

  localparam logic [CONF_BITS-1:0]  CONF_MAX   = {CONF_BITS{1'b1}};
  localparam logic [CONF_BITS-1:0]  CONF_TH    = CONF_BITS'(CONF_THRESH);
  localparam logic [CONF_BITS-1:0]  CONF_ONE   = CONF_BITS'(1);
  localparam logic [AW-1:0]         AHEAD_MAX  = AW'(DEGREE);
  localparam logic [BW-1:0]         STRIDE_MAX = BW'(MAX_STRIDE);
  localparam logic [ID_BITS-1:0]    LAST_ID    = ID_BITS'(NUM_STREAMS - 1);
  localparam logic [BLOCK_BITS-1:0] BLK_ZERO   = '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e               state_q    [NUM_STREAMS];
  logic [BW-1:0]        stride_q   [NUM_STREAMS];
  logic [BW-1:0]        last_blk_q [NUM_STREAMS];
  logic [BW-1:0]        next_pf_q  [NUM_STREAMS];
  logic [CONF_BITS-1:0] conf_q     [NUM_STREAMS];
  logic [AW-1:0]        ahead_q    [NUM_STREAMS];

  logic [ID_BITS-1:0]   victim_q;
  logic [ID_BITS-1:0]   rr_q;
  logic                 pf_valid_q;
  logic [ADDR_BITS-1:0] pf_addr_q;
  logic [ID_BITS-1:0]   pf_id_q;
  logic                 flush_valid_q;
  logic [ID_BITS-1:0]   flush_id_q;

  logic [BW-1:0] req_blk;
  logic          range_hit;
  logic          train_evt;

  assign req_blk   = pf_if.inAddrReq[ADDR_BITS-1:BLOCK_BITS];
  assign range_hit = (pf_if.inAddrReq >= pf_if.bar) && (pf_if.inAddrReq <= pf_if.limit);
  assign train_evt = pf_if.en && pf_if.inAddrReqValid && range_hit;

  logic [BW-1:0]        delta       [NUM_STREAMS];
  logic [ADDR_BITS-1:0] pf_byte_arr [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] hit_vec, idle_vec, elig_vec, tgt_vec, own_acc_vec;

  logic                 match_any, idle_any, alloc;
  logic [ID_BITS-1:0]   match_id, idle_id, tgt_id;
  logic [BW-1:0]        d_t;
  logic                 same, zero;
  logic [CONF_BITS-1:0] conf_inc, arm_conf;
  logic                 retrain, evict, flush_now;
  logic                 accept, drop, global_ok, load;
  logic                 grant_any;
  logic [ID_BITS-1:0]   grant_id;
  logic [ADDR_BITS-1:0] grant_addr;

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
    logic neg;
    logic in_win;

    assign delta[gi]       = req_blk - last_blk_q[gi];
    assign neg             = delta[gi][BW-1];
    assign pf_byte_arr[gi] = {next_pf_q[gi], BLK_ZERO};
    assign in_win          = (pf_byte_arr[gi] >= pf_if.bar) && (pf_byte_arr[gi] <= pf_if.limit);
    assign idle_vec[gi]    = (state_q[gi] == S_IDLE);

`ifdef NEG_STRIDE_EN
    logic [BW-1:0] mag;
    assign mag         = neg ? (BW'(0) - delta[gi]) : delta[gi];
    assign hit_vec[gi] = (state_q[gi] != S_IDLE) && (mag <= STRIDE_MAX);
`else
    // Descending deltas are not tracked; they fall through to allocation.
    assign hit_vec[gi] = (state_q[gi] != S_IDLE) && !neg && (delta[gi] <= STRIDE_MAX);
`endif

    // A stream owning the offer register, or being flushed now, cannot issue again.
    assign elig_vec[gi] = (state_q[gi] == S_ACTIVE) && (conf_q[gi] >= CONF_TH) &&
                          (ahead_q[gi] < AHEAD_MAX) && in_win &&
                          !(pf_valid_q && (pf_id_q == ID_BITS'(gi))) &&
                          !(flush_now && (tgt_id == ID_BITS'(gi)));

    assign tgt_vec[gi]     = train_evt && (tgt_id == ID_BITS'(gi));
    assign own_acc_vec[gi] = accept && (pf_id_q == ID_BITS'(gi)) &&
                             !(flush_now && (tgt_id == ID_BITS'(gi)));
  end

  always_comb begin
    match_any = 1'b0;
    match_id  = '0;
    idle_any  = 1'b0;
    idle_id   = '0;
    for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
      if (hit_vec[s]) begin
        match_any = 1'b1;
        match_id  = ID_BITS'(s);
      end
      if (idle_vec[s]) begin
        idle_any = 1'b1;
        idle_id  = ID_BITS'(s);
      end
    end
  end

  always_comb begin
    tgt_id    = match_any ? match_id : (idle_any ? idle_id : victim_q);
    alloc     = train_evt && !match_any;
    d_t       = delta[match_id];
    same      = (d_t == stride_q[match_id]);
    zero      = (d_t == '0);
    conf_inc  = (conf_q[match_id] == CONF_MAX) ? CONF_MAX : conf_q[match_id] + 1'b1;
    arm_conf  = same ? conf_inc : CONF_ONE;
    retrain   = train_evt && match_any && (state_q[match_id] == S_ACTIVE) && !zero && !same;
    evict     = alloc && !idle_any && (state_q[victim_q] == S_ACTIVE);
    flush_now = retrain || evict;
    accept    = pf_if.en && pf_valid_q && pf_if.prefetchReady;
    drop      = flush_now && pf_valid_q && !accept && (tgt_id == pf_id_q);
    global_ok = pf_if.en && !pf_if.almostFull &&
                (pf_if.outstandingReqCnt < pf_if.outstandingReqLimit);
  end

  // Round-robin search begins one past the most recently granted stream.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
      if (!grant_any && elig_vec[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_BITS'(idx);
      end
    end
    grant_addr = pf_byte_arr[grant_id];
    load       = global_ok && grant_any && (!pf_valid_q || accept);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        state_q[s]    <= S_IDLE;
        stride_q[s]   <= '0;
        last_blk_q[s] <= '0;
        next_pf_q[s]  <= '0;
        conf_q[s]     <= '0;
        ahead_q[s]    <= '0;
      end
    end else if (pf_if.en) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (tgt_vec[s] && alloc) begin
          state_q[s]    <= S_ARM;
          last_blk_q[s] <= req_blk;
          stride_q[s]   <= '0;
          conf_q[s]     <= '0;
          ahead_q[s]    <= '0;
        end else if (tgt_vec[s] && !zero && state_q[s] == S_ARM) begin
          last_blk_q[s] <= req_blk;
          stride_q[s]   <= d_t;
          conf_q[s]     <= arm_conf;
          if (arm_conf >= CONF_TH) begin
            state_q[s]   <= S_ACTIVE;
            next_pf_q[s] <= req_blk + d_t;
            ahead_q[s]   <= '0;
          end
        end else if (tgt_vec[s] && !zero && !same) begin
          state_q[s]    <= S_ARM;
          last_blk_q[s] <= req_blk;
          stride_q[s]   <= d_t;
          conf_q[s]     <= CONF_ONE;
          ahead_q[s]    <= '0;
        end else begin
          // Consumption of one prefetched block and acceptance of one offer cancel out.
          if (tgt_vec[s] && !zero) begin
            conf_q[s]     <= conf_inc;
            last_blk_q[s] <= req_blk;
            if (!own_acc_vec[s] && ahead_q[s] != '0) ahead_q[s] <= ahead_q[s] - 1'b1;
          end else if (own_acc_vec[s]) begin
            ahead_q[s] <= ahead_q[s] + 1'b1;
          end
          if (own_acc_vec[s]) next_pf_q[s] <= next_pf_q[s] + stride_q[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      victim_q      <= '0;
      rr_q          <= '0;
      pf_valid_q    <= 1'b0;
      pf_addr_q     <= '0;
      pf_id_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_id_q    <= '0;
    end else begin
      flush_valid_q <= flush_now;
      if (flush_now) flush_id_q <= tgt_id;
      if (pf_if.en) begin
        if (alloc && !idle_any) victim_q <= (victim_q == LAST_ID) ? '0 : victim_q + 1'b1;
        if (drop) begin
          pf_valid_q <= 1'b0;
        end else if (load) begin
          pf_valid_q <= 1'b1;
          pf_addr_q  <= grant_addr;
          pf_id_q    <= grant_id;
          rr_q       <= grant_id;
        end else if (accept) begin
          pf_valid_q <= 1'b0;
        end
      end
    end
  end

  assign pf_if.rangeHit         = range_hit;
  assign pf_if.prefetchValid    = pf_valid_q;
  assign pf_if.prefetchAddr     = pf_addr_q;
  assign pf_if.prefetchStreamId = pf_id_q;
  assign pf_if.flushValid       = flush_valid_q;
  assign pf_if.flushStreamId    = flush_id_q;

endmodule

// File: doc/multi_stream_prefetch_ctrl.md
Name: multi_stream_prefetch_ctrl

Overview:
Multi-stream, block-aligned stride prefetch controller. It tracks up to NUM_STREAMS independent read streams inside a [bar, limit] window. Each stream trains with a confidence counter. Prefetch addresses are issued through a valid/ready handshake under a per-stream degree limit and global backpressure. It sits between the read-request snoop and the prefetch queue, and supplies per-stream flush pulses to that queue.

Parameters:
ADDR_BITS, 64, request address width
BLOCK_BITS, 6, log2 block size; all prefetch addresses have these low bits zero
NUM_STREAMS, 4, number of tracked streams (>=1)
CONF_BITS, 2, confidence counter width (saturating)
CONF_THRESH, 2, confidence needed to enter/keep active (1..2^CONF_BITS-1)
DEGREE, 4, max accepted-but-unconsumed prefetches per stream
MAX_STRIDE, 16, max |stride| in blocks; also the match window
CNT_BITS, 6, width of outstandingReqCnt/outstandingReqLimit

Ports:
clk  in  1  clock
resetN  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state and outputs
inAddrReqValid  in  1  read request valid
inAddrReq  in  ADDR_BITS  read request byte address
bar  in  ADDR_BITS  window base (inclusive)
limit  in  ADDR_BITS  window limit (inclusive)
almostFull  in  1  prefetch queue almost full
outstandingReqCnt  in  CNT_BITS  in-flight prefetch count
outstandingReqLimit  in  CNT_BITS  in-flight limit
prefetchReady  in  1  downstream accepts prefetch
rangeHit  out  1  combinational: bar <= inAddrReq <= limit
prefetchValid  out  1  prefetch offer valid
prefetchAddr  out  ADDR_BITS  block-aligned prefetch address
prefetchStreamId  out  log2(NUM_STREAMS) (min 1)  owning stream
flushValid  out  1  one-cycle flush pulse
flushStreamId  out  log2(NUM_STREAMS) (min 1)  stream to flush

Behaviour:
- Reset (async, resetN=0): all streams IDLE; stride/conf/ahead/lastBlock = 0; RR pointers = 0; prefetchValid=0, prefetchAddr=0, prefetchStreamId=0, flushValid=0, flushStreamId=0.
- R = inAddrReq >> BLOCK_BITS. d = R - lastBlock_s, computed modulo 2^(ADDR_BITS-BLOCK_BITS) and read as signed.
- A training event is en & inAddrReqValid & rangeHit.
- Matching: stream s matches if not IDLE and |d| <= MAX_STRIDE. When several match, the lowest index wins.
- Allocation (training event, no match): target the lowest-index IDLE stream; otherwise the victim RR pointer, which then increments (mod NUM_STREAMS). If the victim is ACTIVE, flushValid is pulsed for it. The stream loads lastBlock=R, stride=0, conf=0, ahead=0 and goes to ARM.
- ARM, match, d=0: no change.
- ARM, match, d!=0:
  - If d==stride: conf++ (saturating).
  - Else: stride=d, conf=1.
  - lastBlock=R.
  - If the new conf >= CONF_THRESH: go to ACTIVE with nextPf = R + stride and ahead = 0.
- ACTIVE, match, d==stride: conf++ (saturating), ahead-- (saturating at 0), lastBlock=R.
- ACTIVE, match, d!=stride and d!=0: flushValid pulses for s, state goes to ARM, stride=d, conf=1, ahead=0, lastBlock=R.
- ACTIVE, match, d=0: no change.
- Issue eligibility: ACTIVE, conf>=CONF_THRESH, ahead<DEGREE, and nextPf<<BLOCK_BITS within [bar,limit]. Globally, also !almostFull and outstandingReqCnt < outstandingReqLimit.
- Issue arbitration: round-robin across eligible streams, starting after the last granted stream.
- One-entry output register. It loads when empty or accepted in the same cycle. Latency: eligible in cycle N gives prefetchValid in N+1.
- The offer holds stable until prefetchValid & prefetchReady. On acceptance the owning stream does nextPf += stride and ahead++.
- If the stream owning a pending unaccepted offer is flushed or reallocated, the offer is dropped: prefetchValid=0 next cycle.
- A stream never has more than one offer in the register at a time.
- Training update and acceptance on the same stream in the same cycle both apply. The net change to ahead is 0.
- en=0: no training, no issue, no state change. prefetchValid/Addr are held and acceptance is ignored. flushValid=0.
- The window check uses unsigned compare. A nextPf that steps outside the window stalls that stream until it retrains.

Optional Feature:
NEG_STRIDE_EN.
- Defined: negative d values within MAX_STRIDE train normally and produce descending prefetch streams.
- Undefined: any d<0 is treated as a non-match. It neither trains nor flushes an existing stream, so the request goes to allocation. Only ascending streams become ACTIVE.

Test Plan:
1. BLOCK_BITS=6, CONF_THRESH=2, DEGREE=4, bar=0x1000, limit=0x1FFFF, ready=1. Requests 0x1000, 0x1040, 0x1080 -> stream0 ACTIVE. prefetchAddr sequence is 0x10C0, 0x1100, 0x1140, 0x1180, then stalls. The next request 0x10C0 releases 0x11C0.
2. Same training with prefetchReady=0 for 5 cycles -> 0x10C0 is held stable all 5 cycles and accepted once. No skip or duplicate.
3. Active stream0 at stride 1, then request 0x1000+4*0x40+0x80 (d=2) -> flushValid=1 for one cycle with id 0. Stream goes to ARM, no prefetch until retrained.
4. NUM_STREAMS=2. Interleave streams at 0x2000 and 0x8000 (stride 1), then a third stream at 0x10000 -> round-robin victim 0 is reallocated with a flush pulse for id 0. Stream 1 is unaffected.
5. almostFull=1, or outstandingReqCnt==outstandingReqLimit, while active -> prefetchValid stays 0. Deasserting it resumes issue at the next unissued address. resetN low mid-offer -> prefetchValid=0 immediately.
6. NEG_STRIDE_EN defined: requests 0x3000, 0x2FC0, 0x2F80 -> prefetches 0x2F40, 0x2F00, and onward. Undefined: no prefetch, and three streams are allocated.
